// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer.
// Accepts a MEM-stage exception, interrupt or ERET and performs the architectural
// CP0 updates (EPC, CAUSE, STATUS) as serial writes on the single mtc0 port. It
// flushes the pipeline for the whole sequence and ends with a one-cycle redirect.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] DS_OFFSET  = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_type_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic        mem_stall_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic        cp0_exc_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic        new_pc_valid_o,
  output logic [31:0] new_pc_o
);

  localparam logic [4:0] AddrStatus = 5'd12;
  localparam logic [4:0] AddrCause  = 5'd13;
  localparam logic [4:0] AddrEpc    = 5'd14;

  typedef enum logic [2:0] {
    StIdle,
    StWrEpc,
    StWrCause,
    StWrStatus,
    StRedirect
  } state_e;

  state_e      state_q;
  logic [31:0] status_q, cause_q, epc_q, pc_q;
  logic        bd_q, eret_q;
  logic [4:0]  code_q;

  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        int_pending, take_exc, is_eret, accept;
  logic [4:0]  code_sel;

  // CAUSE write word: BD comes from the delay-slot flag only on first-level entry.
  function automatic logic [31:0] cause_word(input logic bd, input logic exl,
                                             input logic [31:0] cause, input logic [4:0] code);
    logic [31:0] w;
    w      = cause;
    w[31]  = exl ? cause[31] : bd;
    w[6:2] = code;
    return w;
  endfunction

  // Effective CP0 values with forwarding from a pending mtc0 in WB.
  always_comb begin
    status_eff = status_i;
    cause_eff  = cause_i;
    epc_eff    = epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == AddrStatus) status_eff = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == AddrEpc)    epc_eff    = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == AddrCause) begin
      // Only the software-writable CAUSE fields are forwarded.
      cause_eff[23:22] = wb_cp0_data_i[23:22];
      cause_eff[9:8]   = wb_cp0_data_i[9:8];
    end
  end

  // Cause priority decode and acceptance.
  always_comb begin
    int_pending = status_eff[0] & ~status_eff[1] & (|(cause_eff[15:8] & status_eff[15:8]));
    take_exc    = 1'b1;
    is_eret     = 1'b0;
    code_sel    = 5'h00;
    if (int_pending)        code_sel = 5'h00;
    else if (exc_type_i[4]) code_sel = 5'h0A;
    else if (exc_type_i[3]) code_sel = 5'h08;
    else if (exc_type_i[2]) code_sel = 5'h09;
    else if (exc_type_i[1]) code_sel = 5'h0C;
    else if (exc_type_i[0]) begin
      take_exc = 1'b0;
      is_eret  = 1'b1;
    end else begin
      take_exc = 1'b0;
    end
    accept = (state_q == StIdle) & exc_valid_i & ~mem_stall_i & (take_exc | is_eret);
  end

  // Sequencer FSM with registered CP0-port, flush and redirect outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      status_q       <= '0;
      cause_q        <= '0;
      epc_q          <= '0;
      pc_q           <= '0;
      bd_q           <= 1'b0;
      eret_q         <= 1'b0;
      code_q         <= '0;
      cp0_we_o       <= 1'b0;
      cp0_waddr_o    <= '0;
      cp0_data_o     <= '0;
      cp0_exc_o      <= 1'b0;
      flush_o        <= 1'b0;
      busy_o         <= 1'b0;
      new_pc_valid_o <= 1'b0;
      new_pc_o       <= '0;
    end else begin
      cp0_we_o       <= 1'b0;
      cp0_waddr_o    <= '0;
      cp0_data_o     <= '0;
      cp0_exc_o      <= 1'b0;
      new_pc_valid_o <= 1'b0;
      new_pc_o       <= '0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            status_q <= status_eff;
            cause_q  <= cause_eff;
            epc_q    <= epc_eff;
            pc_q     <= pc_i;
            bd_q     <= in_delayslot_i;
            eret_q   <= is_eret;
            code_q   <= code_sel;
            flush_o  <= 1'b1;
            busy_o   <= 1'b1;
            cp0_we_o <= 1'b1;
            if (is_eret) begin
              state_q     <= StWrStatus;
              cp0_waddr_o <= AddrStatus;
              cp0_data_o  <= status_eff & ~32'h2;
            end else if (status_eff[1]) begin
              // Nested exception: EPC keeps the original return address.
              state_q     <= StWrCause;
              cp0_exc_o   <= 1'b1;
              cp0_waddr_o <= AddrCause;
              cp0_data_o  <= cause_word(in_delayslot_i, 1'b1, cause_eff, code_sel);
            end else begin
              state_q     <= StWrEpc;
              cp0_waddr_o <= AddrEpc;
              cp0_data_o  <= in_delayslot_i ? pc_i - DS_OFFSET : pc_i;
            end
          end
        end
        StWrEpc: begin
          state_q     <= StWrCause;
          cp0_we_o    <= 1'b1;
          cp0_exc_o   <= 1'b1;
          cp0_waddr_o <= AddrCause;
          cp0_data_o  <= cause_word(bd_q, status_q[1], cause_q, code_q);
        end
        StWrCause: begin
          state_q     <= StWrStatus;
          cp0_we_o    <= 1'b1;
          cp0_waddr_o <= AddrStatus;
          cp0_data_o  <= status_q | 32'h2;
        end
        StWrStatus: begin
          state_q        <= StRedirect;
          new_pc_valid_o <= 1'b1;
          new_pc_o       <= eret_q ? epc_q : EXC_VECTOR;
        end
        StRedirect: begin
          state_q <= StIdle;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exc_valid_i = 1'b0;
  logic [4:0]  exc_type_i = '0;
  logic [31:0] pc_i = '0;
  logic        in_delayslot_i = 1'b0;
  logic        mem_stall_i = 1'b0;
  logic [31:0] status_i = '0;
  logic [31:0] cause_i = '0;
  logic [31:0] epc_i = '0;
  logic        wb_cp0_we_i = 1'b0;
  logic [4:0]  wb_cp0_waddr_i = '0;
  logic [31:0] wb_cp0_data_i = '0;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_data_o;
  logic        cp0_exc_o;
  logic        flush_o;
  logic        busy_o;
  logic        new_pc_valid_o;
  logic [31:0] new_pc_o;

  cp0_exc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .exc_valid_i    (exc_valid_i),
    .exc_type_i     (exc_type_i),
    .pc_i           (pc_i),
    .in_delayslot_i (in_delayslot_i),
    .mem_stall_i    (mem_stall_i),
    .status_i       (status_i),
    .cause_i        (cause_i),
    .epc_i          (epc_i),
    .wb_cp0_we_i    (wb_cp0_we_i),
    .wb_cp0_waddr_i (wb_cp0_waddr_i),
    .wb_cp0_data_i  (wb_cp0_data_i),
    .cp0_we_o       (cp0_we_o),
    .cp0_waddr_o    (cp0_waddr_o),
    .cp0_data_o     (cp0_data_o),
    .cp0_exc_o      (cp0_exc_o),
    .flush_o        (flush_o),
    .busy_o         (busy_o),
    .new_pc_valid_o (new_pc_valid_o),
    .new_pc_o       (new_pc_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-cycle output capture; index 0 is the cycle after acceptance.
  logic        cap_we[7];
  logic [4:0]  cap_addr[7];
  logic [31:0] cap_data[7];
  logic        cap_exc[7];
  logic        cap_flush[7];
  logic        cap_busy[7];
  logic        cap_npv[7];
  logic [31:0] cap_npc[7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    exc_valid_i    = 1'b0;
    exc_type_i     = '0;
    pc_i           = '0;
    in_delayslot_i = 1'b0;
    mem_stall_i    = 1'b0;
    status_i       = '0;
    cause_i        = '0;
    epc_i          = '0;
    wb_cp0_we_i    = 1'b0;
    wb_cp0_waddr_i = '0;
    wb_cp0_data_i  = '0;
  endtask

  // Inputs already set for cycle N; the next edge accepts.
  task automatic fire_and_capture();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        exc_valid_i = 1'b0;
        wb_cp0_we_i = 1'b0;
      end
      cap_we[i]    = cp0_we_o;
      cap_addr[i]  = cp0_waddr_o;
      cap_data[i]  = cp0_data_o;
      cap_exc[i]   = cp0_exc_o;
      cap_flush[i] = flush_o;
      cap_busy[i]  = busy_o;
      cap_npv[i]   = new_pc_valid_o;
      cap_npc[i]   = new_pc_o;
    end
  endtask

  function automatic int flush_count();
    int n = 0;
    for (int i = 0; i < 7; i++) n += int'(cap_flush[i]);
    return n;
  endfunction

  function automatic logic [31:0] all_outs();
    return {cp0_we_o, cp0_exc_o, flush_o, busy_o, new_pc_valid_o, cp0_waddr_o} |
           cp0_data_o | new_pc_o;
  endfunction

  initial begin
    #1;
    check("reset_outs", all_outs(), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Interrupt IP2 enabled, not in delay slot.
    status_i = 32'h1000_0401; cause_i = 32'h0000_0400; pc_i = 32'h100; exc_valid_i = 1'b1;
    fire_and_capture();
    check("int_epc_addr", 32'(cap_addr[0]), 32'd14);
    check("int_epc_data", cap_data[0], 32'h100);
    check("int_cause_addr", 32'(cap_addr[1]), 32'd13);
    check("int_cause_data", cap_data[1], 32'h0000_0400);
    check("int_cause_exc", 32'(cap_exc[1]), 32'd1);
    check("int_epc_exc", 32'(cap_exc[0]), 32'd0);
    check("int_status_addr", 32'(cap_addr[2]), 32'd12);
    check("int_status_data", cap_data[2], 32'h1000_0403);
    check("int_redir_we", 32'(cap_we[3]), 32'd0);
    check("int_redir_valid", 32'(cap_npv[3]), 32'd1);
    check("int_redir_pc", cap_npc[3], 32'h20);
    check("int_redir_early", 32'(cap_npv[2]), 32'd0);
    check("int_flush_cnt", 32'(flush_count()), 32'd4);
    check("int_busy_n4", 32'(cap_busy[3]), 32'd1);
    check("int_idle_busy", 32'(cap_busy[4]), 32'd0);
    check("int_idle_npv", 32'(cap_npv[4]), 32'd0);

    // Syscall in a delay slot.
    @(negedge clk); clear_inputs();
    exc_type_i = 5'b01000; pc_i = 32'h208; in_delayslot_i = 1'b1;
    status_i = 32'h1000_0000; exc_valid_i = 1'b1;
    fire_and_capture();
    check("sys_epc_data", cap_data[0], 32'h204);
    check("sys_cause_data", cap_data[1], 32'h8000_0020);
    check("sys_status_data", cap_data[2], 32'h1000_0002);
    check("sys_flush_cnt", 32'(flush_count()), 32'd4);

    // RI and overflow together: RI wins.
    @(negedge clk); clear_inputs();
    exc_type_i = 5'b10010; pc_i = 32'h300; exc_valid_i = 1'b1;
    fire_and_capture();
    check("ri_epc_data", cap_data[0], 32'h300);
    check("ri_cause_data", cap_data[1], 32'h0000_0028);

    // Same RI with EXL already set: no EPC write, BD kept from CAUSE.
    @(negedge clk); clear_inputs();
    exc_type_i = 5'b10010; pc_i = 32'h300; status_i = 32'h2; cause_i = 32'h8000_0000;
    exc_valid_i = 1'b1;
    fire_and_capture();
    check("nest_first_addr", 32'(cap_addr[0]), 32'd13);
    check("nest_cause_data", cap_data[0], 32'h8000_0028);
    check("nest_cause_exc", 32'(cap_exc[0]), 32'd1);
    check("nest_status_data", cap_data[1], 32'h2);
    check("nest_redir_pc", cap_npc[2], 32'h20);
    check("nest_redir_valid", 32'(cap_npv[2]), 32'd1);
    check("nest_flush_cnt", 32'(flush_count()), 32'd3);

    // ERET with EPC forwarded from WB.
    @(negedge clk); clear_inputs();
    exc_type_i = 5'b00001; status_i = 32'h0000_0003; epc_i = 32'h1234;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h5678; exc_valid_i = 1'b1;
    fire_and_capture();
    check("eret_status_addr", 32'(cap_addr[0]), 32'd12);
    check("eret_status_data", cap_data[0], 32'h1);
    check("eret_redir_valid", 32'(cap_npv[1]), 32'd1);
    check("eret_redir_pc", cap_npc[1], 32'h5678);
    check("eret_flush_cnt", 32'(flush_count()), 32'd2);

    // Stall holds off acceptance.
    @(negedge clk); clear_inputs();
    status_i = 32'h1000_0401; cause_i = 32'h0000_0400; pc_i = 32'h100;
    exc_valid_i = 1'b1; mem_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_flush", 32'(flush_o), 32'd0);
      check("stall_we", 32'(cp0_we_o), 32'd0);
    end
    @(negedge clk); mem_stall_i = 1'b0;
    fire_and_capture();
    check("stall_epc_addr", 32'(cap_addr[0]), 32'd14);
    check("stall_redir_valid", 32'(cap_npv[3]), 32'd1);

    // Reset during WR_CAUSE aborts the sequence.
    @(negedge clk); clear_inputs();
    status_i = 32'h1000_0401; cause_i = 32'h0000_0400; pc_i = 32'h100; exc_valid_i = 1'b1;
    @(posedge clk); #1; exc_valid_i = 1'b0;
    @(posedge clk); #1;
    check("rstmid_cause_addr", 32'(cp0_waddr_o), 32'd13);
    rst = 1'b0;
    #1;
    check("rstmid_outs", all_outs(), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstmid_after", all_outs(), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
